// File: rtl/ps2_key_accumulator.sv
// Purpose: builds a hex value from PS/2 key scan codes and commits it to reg_data on Enter.
// Latency: 1 cycle from a scan_valid byte to every output update.
// Backpressure: none; a byte can be accepted on every cycle, and an Enter during a hold restarts the strobe.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   scan_code/scan_valid byte stream from the PS/2 receiver
//   temp_data/digit_cnt working value being typed and its digit count
//   reg_data            last committed value
//   enter               stretched commit strobe (ENTER_HOLD cycles)
//   key_pulse           one-cycle pulse per acted-on make code
module ps2_key_accumulator #(
  parameter int ENTER_HOLD = 1_000_000,
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  output logic [31:0] temp_data,
  output logic [31:0] reg_data,
  output logic [3:0]  digit_cnt,
  output logic        enter,
  output logic        key_pulse
);

  localparam int CW = (ENTER_HOLD > 1) ? $clog2(ENTER_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt;
  logic [4:0]    dec;
  logic          do_digit, do_bs, do_esc, do_commit;

  // Returns {is_hex_key, nibble} for the 16 hex-digit make codes.
  function automatic logic [4:0] hex_decode(input logic [7:0] code);
    case (code)
      8'h45: hex_decode = 5'h10;
      8'h16: hex_decode = 5'h11;
      8'h1E: hex_decode = 5'h12;
      8'h26: hex_decode = 5'h13;
      8'h25: hex_decode = 5'h14;
      8'h2E: hex_decode = 5'h15;
      8'h36: hex_decode = 5'h16;
      8'h3D: hex_decode = 5'h17;
      8'h3E: hex_decode = 5'h18;
      8'h46: hex_decode = 5'h19;
      8'h1C: hex_decode = 5'h1A;
      8'h32: hex_decode = 5'h1B;
      8'h21: hex_decode = 5'h1C;
      8'h23: hex_decode = 5'h1D;
      8'h24: hex_decode = 5'h1E;
      8'h2B: hex_decode = 5'h1F;
      default: hex_decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_digit  = 1'b0;
    do_bs     = 1'b0;
    do_esc    = 1'b0;
    do_commit = 1'b0;
    dec       = hex_decode(scan_code);
    if (scan_valid) begin
      case (state)
        S_IDLE: begin
          if (scan_code == 8'hF0)      state_nxt = S_BRK;
          else if (scan_code == 8'hE0) state_nxt = S_EXT;
          else if (dec[4])             do_digit  = (digit_cnt < 4'(MAX_DIGITS));
          else if (scan_code == 8'h66) do_bs     = (digit_cnt != 4'd0);
          else if (scan_code == 8'h76) do_esc    = 1'b1;
          else if (scan_code == 8'h5A) do_commit = 1'b1;
        end
        S_EXT: begin
          if (scan_code == 8'hF0) begin
            state_nxt = S_BRK;
          end else begin
            state_nxt = S_IDLE;
            do_commit = (scan_code == 8'h5A);
          end
        end
        // Release byte: whatever follows F0 (even another prefix) is dropped.
        S_BRK:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_data <= 32'd0;
      reg_data  <= 32'd0;
      digit_cnt <= 4'd0;
      enter     <= 1'b0;
      key_pulse <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      key_pulse <= do_digit | do_bs | do_esc | do_commit;

      if (do_commit) begin
        reg_data  <= temp_data;
        temp_data <= 32'd0;
        digit_cnt <= 4'd0;
      end else if (do_esc) begin
        temp_data <= 32'd0;
        digit_cnt <= 4'd0;
      end else if (do_digit) begin
        temp_data <= {temp_data[27:0], dec[3:0]};
        digit_cnt <= digit_cnt + 4'd1;
      end else if (do_bs) begin
        temp_data <= temp_data >> 4;
        digit_cnt <= digit_cnt - 4'd1;
      end

      // A commit always restarts the full hold, even mid-stretch.
      if (do_commit) begin
        enter    <= 1'b1;
        hold_cnt <= CW'(ENTER_HOLD - 1);
      end else if (enter) begin
        if (hold_cnt == '0) enter    <= 1'b0;
        else                hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_accumulator.sv
module tb_ps2_key_accumulator;

  localparam int HOLD = 10;

  logic        clk;
  logic        rst_n;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [31:0] temp_data;
  logic [31:0] reg_data;
  logic [3:0]  digit_cnt;
  logic        enter;
  logic        key_pulse;

  int errors = 0;
  int checks = 0;
  logic kp;

  ps2_key_accumulator #(.ENTER_HOLD(HOLD), .MAX_DIGITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .temp_data  (temp_data),
    .reg_data   (reg_data),
    .digit_cnt  (digit_cnt),
    .enter      (enter),
    .key_pulse  (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; presents one byte for one cycle and returns at the
  // next negedge, where the registered result and key_pulse are visible.
  task automatic send(input logic [7:0] c);
    scan_code  = c;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    kp = key_pulse;
  endtask

  // Counts negedge samples with enter high, bounded.
  task automatic count_enter(output int n);
    n = 0;
    while (enter === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scan_code = 8'h00; scan_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (temp_data !== 32'd0) begin errors++; $display("FAIL reset_temp got %h want 0", temp_data); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL reset_reg got %h want 0", reg_data); end
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", digit_cnt); end
    checks++; if (enter !== 1'b0) begin errors++; $display("FAIL reset_enter got %b want 0", enter); end
    checks++; if (key_pulse !== 1'b0) begin errors++; $display("FAIL reset_kp got %b want 0", key_pulse); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_commit;
    int n;
    send(8'h16);
    checks++; if (temp_data !== 32'h1 || kp !== 1'b1) begin errors++; $display("FAIL basic_first_digit got %h/%b want 1/1", temp_data, kp); end
    send(8'hF0);
    checks++; if (kp !== 1'b0) begin errors++; $display("FAIL basic_prefix_kp got %b want 0", kp); end
    send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
    checks++; if (temp_data !== 32'h12 || digit_cnt !== 4'd2) begin errors++; $display("FAIL basic_typed got %h/%0d want 12/2", temp_data, digit_cnt); end
    send(8'h5A);
    checks++; if (reg_data !== 32'h12 || temp_data !== 32'd0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL basic_commit got reg %h temp %h cnt %0d want 12/0/0", reg_data, temp_data, digit_cnt); end
    checks++; if (enter !== 1'b1 || kp !== 1'b1) begin errors++; $display("FAIL basic_enter_kp got %b/%b want 1/1", enter, kp); end
    count_enter(n);
    checks++; if (n != HOLD) begin errors++; $display("FAIL basic_hold_len got %0d want %0d", n, HOLD); end
    checks++; if (reg_data !== 32'h12) begin errors++; $display("FAIL basic_reg_kept got %h want 12", reg_data); end
  endtask

  task automatic test_overflow;
    logic [7:0] codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    foreach (codes[i]) send(codes[i]);
    checks++; if (temp_data !== 32'h12345678 || digit_cnt !== 4'd8) begin errors++; $display("FAIL ovf_full got %h/%0d want 12345678/8", temp_data, digit_cnt); end
    send(8'h46);
    checks++; if (temp_data !== 32'h12345678 || digit_cnt !== 4'd8 || kp !== 1'b0) begin errors++; $display("FAIL ovf_drop got %h/%0d kp %b want 12345678/8 kp 0", temp_data, digit_cnt, kp); end
    send(8'h76);
    checks++; if (temp_data !== 32'd0 || digit_cnt !== 4'd0) begin errors++; $display("FAIL ovf_esc got %h/%0d want 0/0", temp_data, digit_cnt); end
  endtask

  task automatic test_backspace;
    send(8'h1C); send(8'h32);
    checks++; if (temp_data !== 32'hAB) begin errors++; $display("FAIL bs_typed got %h want ab", temp_data); end
    send(8'h66);
    checks++; if (temp_data !== 32'hA || digit_cnt !== 4'd1 || kp !== 1'b1) begin errors++; $display("FAIL bs_one got %h/%0d kp %b want a/1/1", temp_data, digit_cnt, kp); end
    send(8'h66);
    checks++; if (temp_data !== 32'd0 || digit_cnt !== 4'd0 || kp !== 1'b1) begin errors++; $display("FAIL bs_two got %h/%0d kp %b want 0/0/1", temp_data, digit_cnt, kp); end
    send(8'h66);
    checks++; if (digit_cnt !== 4'd0 || kp !== 1'b0) begin errors++; $display("FAIL bs_empty got %0d kp %b want 0 kp 0", digit_cnt, kp); end
  endtask

  task automatic test_extended;
    int n;
    send(8'h3D);
    send(8'hE0); send(8'h5A);
    checks++; if (reg_data !== 32'h7 || temp_data !== 32'd0 || enter !== 1'b1) begin errors++; $display("FAIL ext_commit got reg %h temp %h en %b want 7/0/1", reg_data, temp_data, enter); end
    count_enter(n);
    checks++; if (n != HOLD) begin errors++; $display("FAIL ext_hold_len got %0d want %0d", n, HOLD); end
    send(8'h16);
    send(8'hE0); send(8'hF0); send(8'h5A);
    checks++; if (reg_data !== 32'h7 || enter !== 1'b0 || temp_data !== 32'h1) begin errors++; $display("FAIL ext_release got reg %h en %b temp %h want 7/0/1", reg_data, enter, temp_data); end
    send(8'h1E);
    checks++; if (temp_data !== 32'h12) begin errors++; $display("FAIL ext_back_idle got %h want 12", temp_data); end
    send(8'h76);
  endtask

  task automatic test_break_esc;
    send(8'hF0); send(8'h45);
    checks++; if (digit_cnt !== 4'd0 || temp_data !== 32'd0) begin errors++; $display("FAIL brk_discard got %h/%0d want 0/0", temp_data, digit_cnt); end
    send(8'hF0); send(8'hE0); send(8'h26);
    checks++; if (temp_data !== 32'h3) begin errors++; $display("FAIL brk_no_nest got %h want 3", temp_data); end
    send(8'h21);
    checks++; if (temp_data !== 32'h3C) begin errors++; $display("FAIL brk_typed got %h want 3c", temp_data); end
    send(8'h11);
    checks++; if (temp_data !== 32'h3C || kp !== 1'b0) begin errors++; $display("FAIL unknown_code got %h kp %b want 3c kp 0", temp_data, kp); end
    send(8'h76);
    checks++; if (temp_data !== 32'd0 || digit_cnt !== 4'd0 || kp !== 1'b1) begin errors++; $display("FAIL esc got %h/%0d kp %b want 0/0/1", temp_data, digit_cnt, kp); end
  endtask

  task automatic test_retrigger;
    int hc, n;
    send(8'h2E);
    send(8'h5A);
    checks++; if (reg_data !== 32'h5) begin errors++; $display("FAIL retrig_first got %h want 5", reg_data); end
    hc = (enter === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (enter === 1'b1) hc++;
    end
    send(8'h5A);
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL retrig_empty_commit got %h want 0", reg_data); end
    count_enter(n);
    checks++; if (hc + n != 5 + HOLD) begin errors++; $display("FAIL retrig_len got %0d want %0d", hc + n, 5 + HOLD); end
  endtask

  task automatic test_reset_mid_hold;
    send(8'h46);
    send(8'h5A);
    send(8'h16);
    checks++; if (temp_data !== 32'h1 || enter !== 1'b1) begin errors++; $display("FAIL hold_typing got %h en %b want 1/1", temp_data, enter); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (temp_data !== 32'd0 || reg_data !== 32'd0 || digit_cnt !== 4'd0 || enter !== 1'b0 || key_pulse !== 1'b0)
      begin errors++; $display("FAIL async_reset got %h %h %0d %b %b want all 0", temp_data, reg_data, digit_cnt, enter, key_pulse); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h1E);
    checks++; if (temp_data !== 32'h2) begin errors++; $display("FAIL post_reset got %h want 2", temp_data); end
  endtask

  initial begin
    kp = 1'b0;
    test_reset;
    test_basic_commit;
    test_overflow;
    test_backspace;
    test_extended;
    test_break_esc;
    test_retrigger;
    test_reset_mid_hold;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
